conv_block_sequencer: RTL and testbench
=======================================

// Module: conv_block_sequencer
// PURPOSE
// - Sequences the 64B/66B->8B/10B converter top (original or error-injected path) one 66-bit block at a time.
// - Accepts a block on a valid/ready input handshake, then drives the converter's reset, en and error-injection controls in a fixed schedule.
// - Captures the 80-bit 8B/10B result and its error flags, and presents them on a valid/ready output handshake.
// - Sits between the block source and the converter top; replaces hand-timed rst/en pulsing.
// PARAMETERS
// - RST_CYCLES     1   converter reset pulse length per block, in cycles (>=1)
// - EN_CYCLES      4   cycles conv_en is held high per block (>=1)
// - SETTLE_CYCLES  2   idle cycles after conv_en drops, before capture (>=0)
// - CNT_W          16  width of the error statistics counters (used only with CONV_ERR_STATS_EN)
// PORTS
// - clk            in   1      system clock, rising edge
// - rst            in   1      asynchronous reset, active-high
// - in_valid       in   1      input block valid
// - in_ready       out  1      sequencer can accept a block
// - in_data        in   66     66-bit block (sync header + payload)
// - in_kin         in   1      control-character flag for this block
// - in_inject      in   1      enable error injection for this block
// - conv_rst       out  1      converter reset
// - conv_en        out  1      converter enable
// - conv_inj_en    out  1      converter error_injection_enable
// - conv_din       out  66     converter din_66b
// - conv_kin       out  1      converter kin
// - conv_dout      in   80     converter dout (8 x 10b symbols)
// - conv_disp_err  in   1      converter disparity error flag
// - conv_kin_err   in   1      converter kin error flag
// - out_valid      out  1      captured result valid
// - out_ready      in   1      downstream accepts the result
// - out_data       out  80     captured conv_dout
// - out_err        out  2      captured flags: {kin_err, disp_err}
// - busy           out  1      high in any state other than IDLE
// BEHAVIOUR
// - Reset values: state IDLE; all registered outputs 0; latched block 0.
// - conv_rst = rst | (state==CRST), so the converter is held in reset while rst is high.
// - FSM:
//   - IDLE:   in_ready=1. On in_valid, latch data, kin and inject, then go to CRST.
//   - CRST:   conv_rst=1 for RST_CYCLES cycles, then go to RUN.
//   - RUN:    conv_en=1 for EN_CYCLES cycles, then go to SETTLE (or CAPTURE if SETTLE_CYCLES==0).
//   - SETTLE: conv_en=0 for SETTLE_CYCLES cycles, then go to CAPTURE.
//   - CAPTURE: one cycle. Register conv_dout into out_data and {kin_err, disp_err} into out_err, then go to HOLD.
//   - HOLD:   out_valid=1; out_data and out_err stable. On out_ready, go to IDLE.
// - conv_din, conv_kin and conv_inj_en are driven from the latched block in every state except IDLE; they are 0 in IDLE.
// - Latency: out_valid rises RST_CYCLES+EN_CYCLES+SETTLE_CYCLES+1 edges after the accept edge (8 with defaults).
// - Single phase counter, $clog2(max(RST_CYCLES,EN_CYCLES,SETTLE_CYCLES)+1) bits wide. It loads 0 on every state entry.
// - in_valid outside IDLE is ignored and in_ready stays 0; no buffering (one block in flight).
// - out_ready high in the cycle out_valid first rises: the transfer completes that edge. in_ready returns the next cycle.
// - out_ready outside HOLD has no effect.
// - rst mid-block: immediate return to IDLE; out_valid, out_data, out_err and latched block cleared; the block is dropped.
// CONFIGURATION
// - Macro CONV_ERR_STATS_EN.
// - Defined: adds these ports:
//   - stats_clr     in   1
//   - disp_err_cnt  out  CNT_W
//   - kin_err_cnt   out  CNT_W
// - In CAPTURE, each counter increments by 1 if its captured flag is 1. Counters saturate at all-ones.
// - stats_clr zeroes both counters and wins over a same-cycle increment. Counters reset to 0.
// - Undefined: these ports and the counters are absent; all other behaviour is identical.
// TESTING
// - Hold stimulus: in_valid=1, in_data=66'h0, in_kin=0, in_inject=0, out_ready=0.
//   -> in_ready drops the edge after accept; conv_rst high 1 cycle, then conv_en high exactly 4 cycles.
//   -> out_valid at accept+8; out_data = conv_dout sampled in CAPTURE; held stable until out_ready.
// - in_data=66'h123456789ABCDEF with in_inject=1: conv_inj_en=1 from CRST through HOLD.
//   -> 0 in IDLE after out_ready; conv_din equals the latched value throughout.
// - in_valid held high in RUN with in_data changed to 66'h3FFFFFFFFFFFFFFFF -> conv_din unchanged; second block accepted only after HOLD->IDLE.
// - rst pulsed during RUN -> conv_rst=1, conv_en=0, out_valid=0 immediately; next block processed normally with full latency.
// - out_ready=1 before out_valid -> single transfer at the out_valid rise; in_ready=1 the following cycle.
// - CONV_ERR_STATS_EN: force conv_disp_err=1 for 3 blocks -> disp_err_cnt=3, kin_err_cnt=0.
//   -> stats_clr coincident with a 4th error capture -> disp_err_cnt=0.
//   -> CNT_W=2 with 5 errors -> disp_err_cnt=3 (saturated).

Source files
------------

// File: rtl/conv_block_sequencer.sv
//==============================================================================
// Module      : conv_block_sequencer
// Description : Runs one 66-bit block at a time through the 64B/66B->8B/10B
//               converter (reset, enable, settle, capture) and returns the
//               80-bit result on a valid/ready handshake.
//               Optional error statistics: define CONV_ERR_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_block_sequencer #(
  parameter int RST_CYCLES    = 1,
  parameter int EN_CYCLES     = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [65:0]       in_data,
  input  logic              in_kin,
  input  logic              in_inject,
  output logic              conv_rst,
  output logic              conv_en,
  output logic              conv_inj_en,
  output logic [65:0]       conv_din,
  output logic              conv_kin,
  input  logic [79:0]       conv_dout,
  input  logic              conv_disp_err,
  input  logic              conv_kin_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [79:0]       out_data,
  output logic [1:0]        out_err,
`ifdef CONV_ERR_STATS_EN
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  disp_err_cnt,
  output logic [CNT_W-1:0]  kin_err_cnt,
`endif
  output logic              busy
);

  localparam int MAX_RE = (RST_CYCLES > EN_CYCLES) ? RST_CYCLES : EN_CYCLES;
  localparam int MAX_C  = (MAX_RE > SETTLE_CYCLES) ? MAX_RE : SETTLE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] EN_LAST     = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  if (RST_CYCLES < 1 || EN_CYCLES < 1 || SETTLE_CYCLES < 0 || CNT_W < 1) begin : g_bad_params
    $error("conv_block_sequencer: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CRST    = 3'd1,
    S_RUN     = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [65:0]   blk_data_q, blk_data_d;
  logic          blk_kin_q, blk_kin_d;
  logic          blk_inj_q, blk_inj_d;
  logic [79:0]   out_data_q, out_data_d;
  logic [1:0]    out_err_q, out_err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_data_d = blk_data_q;
    blk_kin_d  = blk_kin_q;
    blk_inj_d  = blk_inj_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_data_d = in_data;
          blk_kin_d  = in_kin;
          blk_inj_d  = in_inject;
          state_d    = S_CRST;
          cnt_d      = '0;
        end
      end
      S_CRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (cnt_q == EN_LAST) begin
          state_d = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        out_data_d = conv_dout;
        out_err_d  = {conv_kin_err, conv_disp_err};
        state_d    = S_HOLD;
        cnt_d      = '0;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef CONV_ERR_STATS_EN
  logic [CNT_W-1:0] disp_cnt_q, disp_cnt_d;
  logic [CNT_W-1:0] kin_cnt_q, kin_cnt_d;

  // Clear takes priority over an increment landing in the same cycle.
  always_comb begin
    disp_cnt_d = disp_cnt_q;
    kin_cnt_d  = kin_cnt_q;
    if (stats_clr) begin
      disp_cnt_d = '0;
      kin_cnt_d  = '0;
    end else if (state_q == S_CAPTURE) begin
      if (conv_disp_err && !(&disp_cnt_q)) disp_cnt_d = disp_cnt_q + CNT_W'(1);
      if (conv_kin_err && !(&kin_cnt_q))   kin_cnt_d  = kin_cnt_q + CNT_W'(1);
    end
  end

  assign disp_err_cnt = disp_cnt_q;
  assign kin_err_cnt  = kin_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      blk_data_q <= '0;
      blk_kin_q  <= 1'b0;
      blk_inj_q  <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= '0;
`ifdef CONV_ERR_STATS_EN
      disp_cnt_q <= '0;
      kin_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_data_q <= blk_data_d;
      blk_kin_q  <= blk_kin_d;
      blk_inj_q  <= blk_inj_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
`ifdef CONV_ERR_STATS_EN
      disp_cnt_q <= disp_cnt_d;
      kin_cnt_q  <= kin_cnt_d;
`endif
    end
  end

  // Converter is held in reset for as long as the system reset is asserted.
  assign conv_rst    = rst | (state_q == S_CRST);
  assign conv_en     = (state_q == S_RUN);
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_HOLD);
  assign conv_din    = busy ? blk_data_q : 66'd0;
  assign conv_kin    = busy & blk_kin_q;
  assign conv_inj_en = busy & blk_inj_q;
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_block_sequencer.sv
// Bench for conv_block_sequencer: phase-based model plus directed scenarios.
`default_nettype none

module tb_conv_block_sequencer;

  localparam int R   = 1;
  localparam int E   = 4;
  localparam int S   = 2;
  localparam int LAT = R + E + S + 1;
`ifdef CONV_ERR_STATS_EN
  localparam int CW_T = 2;
`else
  localparam int CW_T = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0, in_kin = 1'b0, in_inject = 1'b0, out_ready = 1'b0;
  logic [65:0] in_data = '0;
  logic        in_ready, conv_rst, conv_en, conv_inj_en, conv_kin, out_valid, busy;
  logic [65:0] conv_din;
  logic [79:0] conv_dout = '0;
  logic        conv_disp_err = 1'b0, conv_kin_err = 1'b0;
  logic [79:0] out_data;
  logic [1:0]  out_err;
`ifdef CONV_ERR_STATS_EN
  logic            stats_clr = 1'b0;
  logic [CW_T-1:0] disp_err_cnt, kin_err_cnt;
  logic            err_force = 1'b0;
  int              m_dc = 0, m_kc = 0;
`endif

  int checks = 0;
  int failures = 0;
  int dcnt = 0;

  conv_block_sequencer #(
    .RST_CYCLES(R), .EN_CYCLES(E), .SETTLE_CYCLES(S), .CNT_W(CW_T)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kin(in_kin), .in_inject(in_inject),
    .conv_rst(conv_rst), .conv_en(conv_en), .conv_inj_en(conv_inj_en),
    .conv_din(conv_din), .conv_kin(conv_kin),
    .conv_dout(conv_dout), .conv_disp_err(conv_disp_err), .conv_kin_err(conv_kin_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
`ifdef CONV_ERR_STATS_EN
    .stats_clr(stats_clr), .disp_err_cnt(disp_err_cnt), .kin_err_cnt(kin_err_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] pat(input int n);
    return {16'hC0DE, 32'(n * 7 + 3), 32'(n)};
  endfunction

  // Converter stand-in: result and flags change every cycle so capture timing is visible.
  always @(negedge clk) begin
    dcnt++;
    conv_dout     = pat(dcnt);
    conv_disp_err = dcnt[0];
    conv_kin_err  = dcnt[2];
`ifdef CONV_ERR_STATS_EN
    if (err_force) begin
      conv_disp_err = 1'b1;
      conv_kin_err  = 1'b0;
    end
`endif
  end

  // Model: m_ph counts edges since the accept edge.
  logic        m_busy = 1'b0, m_ov = 1'b0, m_kin = 1'b0, m_inj = 1'b0;
  int          m_ph = 0;
  logic [65:0] m_data = '0;
  logic [79:0] m_od = '0;
  logic [1:0]  m_oe = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_ov = 0; m_kin = 0; m_inj = 0; m_ph = 0;
      m_data = '0; m_od = '0; m_oe = '0;
`ifdef CONV_ERR_STATS_EN
      m_dc = 0; m_kc = 0;
`endif
    end else begin
`ifdef CONV_ERR_STATS_EN
      logic clr_now;
      clr_now = stats_clr;
`endif
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_ph = 0; m_data = in_data; m_kin = in_kin; m_inj = in_inject;
        end
      end else if (m_ov && out_ready) begin
        m_busy = 0; m_ov = 0;
      end else begin
        if (m_ph == R + E + S) begin
          m_ov = 1; m_od = conv_dout; m_oe = {conv_kin_err, conv_disp_err};
`ifdef CONV_ERR_STATS_EN
          if (conv_disp_err && m_dc < (1 << CW_T) - 1) m_dc++;
          if (conv_kin_err && m_kc < (1 << CW_T) - 1) m_kc++;
`endif
        end
        m_ph++;
      end
`ifdef CONV_ERR_STATS_EN
      if (clr_now) begin m_dc = 0; m_kc = 0; end
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [154:0] act, exp;
    logic e_rst, e_en;
    e_rst = rst | (m_busy && m_ph < R);
    e_en  = m_busy && m_ph >= R && m_ph < R + E;
    act = {in_ready, busy, conv_rst, conv_en, conv_inj_en, conv_kin, out_valid, out_err, conv_din, out_data};
    exp = {!m_busy, m_busy, e_rst, e_en, m_busy & m_inj, m_busy & m_kin, m_ov, m_oe,
           m_busy ? m_data : 66'd0, m_od};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, act, exp);
    end
`ifdef CONV_ERR_STATS_EN
    checks++;
    if (disp_err_cnt !== CW_T'(m_dc) || kin_err_cnt !== CW_T'(m_kc)) begin
      failures++;
      $display("FAIL model_stats t=%0t got=%0d/%0d expected=%0d/%0d", $time,
               disp_err_cnt, kin_err_cnt, m_dc, m_kc);
    end
`endif
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Presents a block and returns just after the accept edge, with the dout index at that point.
  task automatic accept(input logic [65:0] d, input logic k, input logic inj, output int d0);
    int n;
    in_data = d; in_kin = k; in_inject = inj; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("accept_timeout", 0, 1);
    tick();
    d0 = dcnt;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic run_block(input logic [65:0] d, output int d0);
    int n;
    accept(d, 1'b0, 1'b0, d0);
    in_valid = 1'b0;
    wait_valid(n);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    int d0, n, en_cnt, rst_cnt, lat, inj_bad, din_bad;
    rst = 1'b1;
    tick(); tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_conv_rst", conv_rst, 1);
    check("reset_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Hold stimulus: in_valid stays high, out_ready low.
    accept(66'h0, 1'b0, 1'b0, d0);
    check("in_ready_after_accept", in_ready, 0);
    en_cnt = 0; rst_cnt = 0; lat = -1;
    for (int i = 0; i <= LAT + 3; i++) begin
      if (conv_en) en_cnt++;
      if (conv_rst) rst_cnt++;
      if (out_valid && lat < 0) lat = i;
      if (i < LAT + 3) tick();
    end
    check("conv_rst_cycles", rst_cnt, 1);
    check("conv_en_cycles", en_cnt, 4);
    check("latency_hold", lat, 8);
    check("out_data_hold", out_data, pat(d0 + 8));
    check("out_err_hold", out_err, {pat(d0 + 8) == pat(d0 + 8) ? 1'(((d0 + 8) >> 2) & 1) : 1'b0,
                                    1'((d0 + 8) & 1)});
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("hold_release_valid", out_valid, 0);
    check("hold_release_ready", in_ready, 1);

    // Injected block: inj_en and din follow the latched block until release.
    accept(66'h123456789ABCDEF, 1'b0, 1'b1, d0);
    in_valid = 1'b0; in_data = '0; in_inject = 1'b0;
    inj_bad = 0; din_bad = 0;
    for (int i = 0; i < 50 && !out_valid; i++) begin
      if (!conv_inj_en) inj_bad++;
      if (conv_din !== 66'h123456789ABCDEF) din_bad++;
      tick();
    end
    check("inj_en_held", inj_bad, 0);
    check("din_held", din_bad, 0);
    check("inj_en_hold_state", conv_inj_en, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("inj_en_idle", conv_inj_en, 0);
    check("din_idle", conv_din, 0);

    // New data on in_valid during RUN must not disturb the block in flight.
    accept(66'h2AAAA5555AAAA5555, 1'b1, 1'b0, d0);
    tick(); tick();
    in_data = 66'h3FFFFFFFFFFFFFFFF;
    wait_valid(n);
    check("din_unchanged", conv_din, 66'h2AAAA5555AAAA5555);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("second_ready_idle", in_ready, 1);
    tick();
    check("second_busy", busy, 1);
    check("second_din", conv_din, 66'h3FFFFFFFFFFFFFFFF);
    in_valid = 1'b0;
    wait_valid(n);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset in RUN drops the block; next block sees full latency.
    accept(66'h15, 1'b0, 1'b1, d0);
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_conv_en", conv_en, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_conv_rst", conv_rst, 1);
    check("mid_rst_conv_en", conv_en, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_din", conv_din, 0);
    tick();
    rst = 1'b0;
    tick();
    accept(66'h2A, 1'b0, 1'b0, d0);
    in_valid = 1'b0;
    wait_valid(n);
    check("latency_after_rst", n, 8);
    check("out_data_after_rst", out_data, pat(d0 + 8));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // out_ready asserted early: one transfer on the out_valid rise.
    out_ready = 1'b1;
    accept(66'h7, 1'b0, 1'b0, d0);
    in_valid = 1'b0;
    wait_valid(n);
    check("latency_early_ready", n, 8);
    tick();
    check("early_ready_single", out_valid, 0);
    check("early_ready_in_ready", in_ready, 1);
    out_ready = 1'b0;
    tick();

`ifdef CONV_ERR_STATS_EN
    // Counters: clear, three errors, clear racing a capture, saturation.
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    err_force = 1'b1;
    for (int b = 0; b < 3; b++) run_block(66'h1, d0);
    check("disp_cnt_3", disp_err_cnt, 3);
    check("kin_cnt_0", kin_err_cnt, 0);
    accept(66'h1, 1'b0, 1'b0, d0);
    in_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick();
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    check("disp_cnt_clr_wins", disp_err_cnt, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int b = 0; b < 5; b++) run_block(66'h1, d0);
    check("disp_cnt_sat", disp_err_cnt, 3);
    err_force = 1'b0;
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
